os_result_drain: RTL and testbench

- Reader at the bottom edge of the output-stationary systolic array.
- After a compute pass, drives the array-wide op_sel to shift each column's Result chain downward and captures one row of results per cycle.
- Buffers captured rows in a small FIFO and presents them downstream on a valid/ready stream, tagged with the source row index.
- Owns op_sel; the array's compute/feeder logic only pulses start.

---
 rtl/os_array_pkg.sv | 19 +
 rtl/os_sync_fifo.sv | 64 ++++++
 rtl/os_result_drain.sv | 115 +++++++++++
 tb/tb_os_result_drain.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/os_array_pkg.sv
// Shared definitions for the output-stationary array result path.
//   - FSM state encoding for the drain controller
//   - row_idx_w(): width of a row index (minimum 1 bit)
// The row-entry struct depends on the instantiating module's COLS and word
// size, so it is declared inside os_result_drain, where those are known.
package os_array_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE       = 2'd0;
   localparam state_t ST_WAIT_SPACE = 2'd1;
   localparam state_t ST_SHIFT      = 2'd2;
   localparam state_t ST_DONE       = 2'd3;

   function automatic int row_idx_w(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/os_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : write request and data (a push while full is only accepted
//                 together with a pop)
//   pop         : read request (ignored while empty)
//   dout        : head entry, zero while empty
//   full, empty : occupancy flags
//   free        : number of unused entries
module os_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   free
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             wr_en, rd_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign free  = CNT_W'(DEPTH) - count;

   // At full, the slot being popped this cycle is the one written.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   // Gate the head so the output reads zero after reset / when drained.
   assign dout = empty ? '0 : mem[rd_ptr];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (!wr_en && rd_en) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/os_result_drain.sv
// Result reader at the bottom edge of an output-stationary systolic array.
// After start, reserves ROWS FIFO entries, then holds op_sel high for ROWS
// cycles so every column's Result chain shifts down one row per cycle,
// capturing each row (bottom row first) with its row index.
//   clk, rst   : clock, synchronous active-high reset
//   start      : pulse, Psums are final
//   result_in  : bottom-row Result_out per column, column c at [c*W +: W]
//   op_sel     : to all PEs, 1 = shift Result chain, 0 = load Psum
//   busy, done : drain in progress / one-cycle completion pulse
//   out_*      : valid/ready stream of captured rows
module os_result_drain
   import os_array_pkg::*;
#(
   parameter int ROWS          = 4,
   parameter int COLS          = 4,
   parameter int out_word_size = 16,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [COLS*out_word_size-1:0]         result_in,
   output logic                                  op_sel,
   output logic                                  busy,
   output logic                                  done,
   output logic [COLS*out_word_size-1:0]         out_data,
   output logic [row_idx_w(ROWS)-1:0]            out_row,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   localparam int DW    = COLS * out_word_size;
   localparam int ROW_W = row_idx_w(ROWS);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   if (FIFO_DEPTH < ROWS) begin : g_bad_depth
      $error("os_result_drain: FIFO_DEPTH must be >= ROWS");
   end

   typedef struct packed {
      logic [DW-1:0]    data;
      logic [ROW_W-1:0] row;
   } row_entry_t;

   state_t           state;
   logic [ROW_W-1:0] k;
   row_entry_t       push_ent, head_ent;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_free;
   logic [CNT_W:0]   free_eff;

   assign op_sel    = (state == ST_SHIFT);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

   assign fifo_push     = op_sel;
   assign push_ent.data = result_in;
   assign push_ent.row  = ROW_W'(ROWS - 1) - k;

   assign out_valid = !fifo_empty;
   assign fifo_pop  = out_valid && out_ready;
   assign out_data  = head_ent.data;
   assign out_row   = head_ent.row;

   // A pop this cycle already frees a slot for the first shift cycle.
   assign free_eff = {1'b0, fifo_free} + (CNT_W+1)'(fifo_pop);

   os_sync_fifo #(
      .WIDTH ($bits(row_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (push_ent),
      .pop   (fifo_pop),
      .dout  (head_ent),
      .full  (fifo_full),
      .empty (fifo_empty),
      .free  (fifo_free)
   );

   // The chain cannot pause once shifting, so space must have been reserved.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(fifo_push && fifo_full && !fifo_pop));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         k     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_WAIT_SPACE;
            end
            ST_WAIT_SPACE: begin
               if (free_eff >= (CNT_W+1)'(ROWS)) begin
                  state <= ST_SHIFT;
                  k     <= '0;
               end
            end
            ST_SHIFT: begin
               if (k == ROW_W'(ROWS - 1)) begin
                  state <= ST_DONE;
                  k     <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: state <= ST_IDLE;   // ST_DONE lasts one cycle
         endcase
      end
   end

endmodule

// File: tb/tb_os_result_drain.sv
module tb_os_result_drain;

   localparam int ROWS = 4, COLS = 2, W = 16, DEPTH = 8;

   logic            clk = 1'b0;
   logic            rst, start, out_ready;
   logic [COLS*W-1:0] result_in, out_data;
   logic [1:0]      out_row;
   logic            op_sel, busy, done, out_valid;

   os_result_drain #(
      .ROWS (ROWS), .COLS (COLS), .out_word_size (W), .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .result_in (result_in),
      .op_sel (op_sel), .busy (busy), .done (done),
      .out_data (out_data), .out_row (out_row),
      .out_valid (out_valid), .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Result chain model: load Psum while op_sel=0, shift down with zero fill.
   logic [W-1:0] psum [COLS][ROWS];
   logic [W-1:0] res  [COLS][ROWS];

   always @(posedge clk) begin
      for (int c = 0; c < COLS; c++) begin
         if (op_sel) begin
            for (int r = ROWS - 1; r > 0; r--) res[c][r] <= res[c][r-1];
            res[c][0] <= '0;
         end else begin
            for (int r = 0; r < ROWS; r++) res[c][r] <= psum[c][r];
         end
      end
   end

   assign result_in = {res[1][ROWS-1], res[0][ROWS-1]};

   int n_vec = 0, n_err = 0;
   int n_shift = 0, n_done = 0, n_xfer = 0;
   logic [33:0] sb [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Transfers are sampled at negedge; inputs only change just after posedge.
   always @(negedge clk) begin
      if (!rst) begin
         if (op_sel) n_shift++;
         if (done)   n_done++;
         if (out_valid && out_ready) begin
            n_xfer++;
            if (sb.size() == 0) chk("xfer_extra", {out_row, out_data}, 64'hdead);
            else                chk("xfer", {out_row, out_data}, sb.pop_front());
         end
      end
   end

   task automatic set_psum(input logic [W-1:0] base);
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            psum[c][r] = base + W'(c * 16'h100) + W'(r);
   endtask

   task automatic exp_drain();
      for (int r = ROWS - 1; r >= 0; r--)
         sb.push_back({2'(r), psum[1][r], psum[0][r]});
   endtask

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic wait_op_sel();
      for (int i = 0; i < 50; i++) begin
         if (op_sel) break;
         @(posedge clk); #1;
      end
      chk("op_sel_timeout", op_sel, 1);
   endtask

   task automatic flush();
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (!out_valid) break;
         @(posedge clk); #1;
      end
      chk("flush_timeout", out_valid, 0);
      @(posedge clk); #1;
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic fill_two(input logic [W-1:0] b0, input logic [W-1:0] b1);
      out_ready = 1'b0;
      set_psum(b0); exp_drain(); do_start(); wait_idle();
      set_psum(b1); exp_drain(); do_start(); wait_idle();
   endtask

   int s0, d0, x0;
   logic [33:0] head;

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      set_psum(16'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_op_sel", op_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", {out_row, out_data}, 0);
      rst = 1'b0;

      // Basic drain with hand-computed rows, bottom row first
      for (int r = 0; r < ROWS; r++) begin
         psum[0][r] = W'(r + 1);
         psum[1][r] = W'((r + 1) * 16'h10);
      end
      sb.push_back({2'd3, 32'h0040_0004});
      sb.push_back({2'd2, 32'h0030_0003});
      sb.push_back({2'd1, 32'h0020_0002});
      sb.push_back({2'd0, 32'h0010_0001});
      out_ready = 1'b1;
      s0 = n_shift; d0 = n_done; x0 = n_xfer;
      do_start();
      chk("busy_up", busy, 1);
      wait_op_sel();
      @(posedge clk); #1;
      chk("fwft_valid", out_valid, 1);
      chk("fwft_row", out_row, 3);
      wait_idle();
      flush();
      chk("basic_shifts", n_shift - s0, 4);
      chk("basic_done", n_done - d0, 1);
      chk("basic_xfers", n_xfer - x0, 4);

      // Backpressure: two drains fill the FIFO, third waits for space
      x0 = n_xfer;
      fill_two(16'h1000, 16'h2000);
      head = {2'd3, 16'h1103, 16'h1003};
      chk("bp_valid", out_valid, 1);
      chk("bp_head", {out_row, out_data}, head);
      repeat (3) @(posedge clk);
      #1 chk("bp_stable", {out_row, out_data}, head);
      set_psum(16'h3000); exp_drain();
      s0 = n_shift;
      do_start();
      repeat (5) @(posedge clk);
      #1;
      chk("bp_wait_busy", busy, 1);
      chk("bp_wait_op_sel", op_sel, 0);
      chk("bp_no_shift", n_shift - s0, 0);
      out_ready = 1'b1;
      wait_idle();
      flush();
      chk("bp_xfers", n_xfer - x0, 12);

      // Space boundary: 5 entries, a pop on the same cycle opens the shift
      fill_two(16'h4000, 16'h5000);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      set_psum(16'h6000); exp_drain();
      do_start();
      @(posedge clk); #1;
      chk("sb_wait_op_sel", op_sel, 0);
      chk("sb_wait_busy", busy, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("sb_same_cycle", op_sel, 1);
      out_ready = 1'b1;
      wait_idle();
      flush();

      // start while busy is ignored
      set_psum(16'h7000); exp_drain();
      s0 = n_shift; d0 = n_done;
      do_start();
      wait_op_sel();
      @(posedge clk); #1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_idle();
      repeat (4) @(posedge clk);
      #1 chk("sib_stays_idle", busy, 0);
      chk("sib_shifts", n_shift - s0, 4);
      chk("sib_done", n_done - d0, 1);
      flush();

      // Reset at SHIFT cycle 1
      out_ready = 1'b0;
      set_psum(16'h8000);
      do_start();
      wait_op_sel();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      sb.delete();
      chk("mid_rst_op_sel", op_sel, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", {out_row, out_data}, 0);
      set_psum(16'h9000); exp_drain();
      out_ready = 1'b1;
      do_start();
      wait_idle();
      flush();

      // Full FIFO with continuous pops during the drain
      x0 = n_xfer;
      fill_two(16'hA000, 16'hB000);
      set_psum(16'hC000); exp_drain();
      out_ready = 1'b1;
      do_start();
      wait_idle();
      flush();
      chk("full_xfers", n_xfer - x0, 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
